// File: rtl/flash_word_fetcher.sv
// flash_word_fetcher: fetches 32-bit words one byte at a time from spi_wrapper, little-endian by default.
// Define FETCH_BSWAP_EN to pack big-endian instead.
module flash_word_fetcher #(
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [23:0]      start_addr_i,
  input  logic [LEN_W-1:0] word_cnt_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             flash_valid_o,
  input  logic             flash_ready_i,
  output logic [23:0]      flash_addr_o,
  input  logic [7:0]       flash_rdata_i,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic [31:0]      word_data_o,
  output logic             word_last_o
);
  typedef enum logic [2:0] {IDLE, REQ, GAP, OUT, DONE} state_t;
  state_t state, state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [1:0] idx, lane;
  logic abort_pend, byte_hs, word_hs, last_word, abort_req;
`ifdef FETCH_BSWAP_EN
  assign lane = ~idx;
`else
  assign lane = idx;
`endif
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign flash_valid_o = state == REQ;
  assign word_valid_o = state == OUT;
  assign last_word = cnt == LEN_W'(1);
  assign word_last_o = word_valid_o & last_word;
  assign byte_hs = flash_valid_o & flash_ready_i;
  assign word_hs = word_valid_o & word_ready_i;
  // an abort seen in REQ waits for the byte in flight so the SPI transfer is never cut short
  assign abort_req = abort_i | abort_pend;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_i) state_nxt = word_cnt_i == '0 ? DONE : REQ;
      REQ: if (flash_ready_i) state_nxt = abort_req ? IDLE : idx == 2'd3 ? OUT : GAP;
      GAP: state_nxt = abort_i ? IDLE : REQ;
      OUT: state_nxt = abort_i ? IDLE : !word_ready_i ? OUT : last_word ? DONE : REQ;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      flash_addr_o <= '0;
      cnt <= '0;
      idx <= '0;
      word_data_o <= '0;
      abort_pend <= 1'b0;
    end else begin
      abort_pend <= state == REQ && !flash_ready_i && abort_req;
      if (state == IDLE && start_i) begin
        flash_addr_o <= start_addr_i;
        cnt <= word_cnt_i;
        idx <= '0;
        word_data_o <= '0;
      end
      if (byte_hs) begin
        word_data_o[{lane, 3'b000} +: 8] <= flash_rdata_i;
        flash_addr_o <= flash_addr_o + 24'd1;
        idx <= idx + 2'd1;
      end
      if (word_hs && !last_word) cnt <= cnt - LEN_W'(1);
    end
endmodule

// File: tb/tb_flash_word_fetcher.sv
// tb_flash_word_fetcher: randomized flash/consumer model with scoreboard for flash_word_fetcher.
module tb_flash_word_fetcher;
  logic clk_i = 0, rst_i = 0, start_i = 0, abort_i = 0, flash_ready_i = 0, word_ready_i = 0;
  logic [23:0] start_addr_i = '0;
  logic [15:0] word_cnt_i = '0;
  logic [7:0] flash_rdata_i = '0;
  logic busy_o, done_o, flash_valid_o, word_valid_o, word_last_o;
  logic [23:0] flash_addr_o;
  logic [31:0] word_data_o;
  int checks = 0, errors = 0;
  logic [7:0] mem [logic [23:0]];
  logic [23:0] hs_q[$];
  logic [31:0] w_q[$];
  logic l_q[$];
  int done_cnt = 0, wv_seen = 0, fv_seen = 0, rdy_pct = 70, hold_after = 1000;
  bit cons_en = 1;
  bit p_hs = 0, p_fv = 0, p_wv = 0, p_wr = 0, p_last = 0;
  logic [31:0] p_data = '0;
  logic [23:0] p_addr = '0;

  flash_word_fetcher dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .start_addr_i(start_addr_i),
    .word_cnt_i(word_cnt_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
    .flash_valid_o(flash_valid_o), .flash_ready_i(flash_ready_i), .flash_addr_o(flash_addr_o),
    .flash_rdata_i(flash_rdata_i), .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .word_data_o(word_data_o), .word_last_o(word_last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [23:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  function automatic logic [31:0] pack(input logic [7:0] b0, b1, b2, b3);
`ifdef FETCH_BSWAP_EN
    return {b0, b1, b2, b3};
`else
    return {b3, b2, b1, b0};
`endif
  endfunction

  // flash responder, word consumer and per-cycle protocol checks
  always @(negedge clk_i) begin
    if (rst_i) begin
      p_hs = 0; p_fv = 0; p_wv = 0;
    end else begin
      flash_ready_i = (hs_q.size() < hold_after) && ($urandom_range(0, 99) < rdy_pct);
      flash_rdata_i = flash_valid_o ? rd(flash_addr_o) : 8'h00;
      word_ready_i = cons_en && ($urandom_range(0, 1) == 1);
      if (p_hs) check("gap_after_byte", flash_valid_o, 0);
      if (p_fv && !p_hs) check("req_addr_hold", {7'd0, flash_valid_o, flash_addr_o}, {7'd0, 1'b1, p_addr});
      if (p_wv && !p_wr && word_valid_o) begin
        check("word_data_hold", word_data_o, p_data);
        check("word_last_hold", word_last_o, p_last);
      end
      check("no_req_in_out", word_valid_o & flash_valid_o, 0);
      if (flash_valid_o && flash_ready_i) hs_q.push_back(flash_addr_o);
      if (word_valid_o && word_ready_i) begin
        w_q.push_back(word_data_o);
        l_q.push_back(word_last_o);
      end
      done_cnt += int'(done_o);
      wv_seen += int'(word_valid_o);
      fv_seen += int'(flash_valid_o);
      p_hs = flash_valid_o && flash_ready_i;
      p_fv = flash_valid_o;
      p_addr = flash_addr_o;
      p_wv = word_valid_o;
      p_wr = word_ready_i;
      p_data = word_data_o;
      p_last = word_last_o;
    end
  end

  task automatic start_xfer(input logic [23:0] a, input int n);
    hs_q.delete(); w_q.delete(); l_q.delete();
    done_cnt = 0; wv_seen = 0; fv_seen = 0;
    start_addr_i = a; word_cnt_i = 16'(n); start_i = 1;
    @(negedge clk_i);
    start_i = 0;
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (busy_o && i < 3000) begin
      @(negedge clk_i);
      i++;
    end
    check({tag, "_timeout"}, busy_o, 0);
  endtask

  task automatic verify(input string tag, input logic [23:0] a, input int n);
    logic [23:0] ea;
    check({tag, "_nbytes"}, hs_q.size(), 4 * n);
    check({tag, "_nwords"}, w_q.size(), n);
    check({tag, "_done"}, done_cnt, 1);
    for (int i = 0; i < hs_q.size() && i < 4 * n; i++) begin
      ea = a + 24'(i);
      check({tag, "_byte_addr"}, hs_q[i], ea);
    end
    for (int i = 0; i < w_q.size() && i < n; i++) begin
      ea = a + 24'(4 * i);
      check({tag, "_word"}, w_q[i], pack(rd(ea), rd(ea + 24'd1), rd(ea + 24'd2), rd(ea + 24'd3)));
      check({tag, "_last"}, l_q[i], i == n - 1);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [23:0] a;
    int n;
    #2 rst_i = 1;
    #1;
    check("rst_flags", {busy_o, done_o, flash_valid_o, word_valid_o, word_last_o}, 0);
    check("rst_addr", flash_addr_o, 0);
    check("rst_data", word_data_o, 0);
    mem[24'h0] = 8'hAA; mem[24'h1] = 8'hBB; mem[24'h2] = 8'hCC; mem[24'h3] = 8'hDD;
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 0;
    start_xfer(24'h0, 1);
    check("start_first_cycle", busy_o, 1);
    wait_idle("basic");
    verify("basic", 24'h0, 1);
`ifdef FETCH_BSWAP_EN
    check("basic_const", w_q.size() > 0 ? w_q[0] : 32'hx, 32'hAABBCCDD);
`else
    check("basic_const", w_q.size() > 0 ? w_q[0] : 32'hx, 32'hDDCCBBAA);
`endif
    cons_en = 0;
    start_xfer(24'h000200, 2);
    for (int i = 0; i < 500 && !word_valid_o; i++) @(negedge clk_i);
    check("stall_wv", word_valid_o, 1);
    d = word_data_o;
    n = fv_seen;
    repeat (20) @(negedge clk_i);
    check("stall_data", word_data_o, d);
    check("stall_valid", word_valid_o, 1);
    check("stall_no_req", fv_seen, n);
    check("stall_bytes", hs_q.size(), 4);
    cons_en = 1;
    wait_idle("stall");
    verify("stall", 24'h000200, 2);
    start_xfer(24'hFFFFFE, 1);
    wait_idle("wrap");
    verify("wrap", 24'hFFFFFE, 1);
    start_xfer(24'h000010, 0);
    check("cnt0_done_pulse", done_o, 1);
    @(negedge clk_i);
    check("cnt0_done_drop", {busy_o, done_o}, 0);
    check("cnt0_no_req", fv_seen, 0);
    check("cnt0_done_cnt", done_cnt, 1);
    hold_after = 1; rdy_pct = 100;
    start_xfer(24'h000300, 2);
    for (int i = 0; i < 200 && !(hs_q.size() == 1 && flash_valid_o && flash_addr_o == 24'h000301); i++)
      @(negedge clk_i);
    check("abort_at_byte2", {7'd0, flash_valid_o, flash_addr_o}, {7'd0, 1'b1, 24'h000301});
    abort_i = 1;
    @(negedge clk_i);
    abort_i = 0;
    repeat (3) @(negedge clk_i);
    check("abort_deferred", {6'd0, busy_o, flash_valid_o, flash_addr_o}, {6'd0, 2'b11, 24'h000301});
    hold_after = 1000;
    wait_idle("abort_req");
    check("abort_req_bytes", hs_q.size(), 2);
    check("abort_req_wv", wv_seen, 0);
    check("abort_req_done", done_cnt, 0);
    rdy_pct = 70;
    cons_en = 0;
    start_xfer(24'h000400, 1);
    for (int i = 0; i < 500 && !word_valid_o; i++) @(negedge clk_i);
    check("abort_out_wv", word_valid_o, 1);
    abort_i = 1;
    @(negedge clk_i);
    abort_i = 0;
    check("abort_out_now", {busy_o, word_valid_o}, 0);
    @(negedge clk_i);
    check("abort_out_done", done_cnt, 0);
    cons_en = 1;
    abort_i = 1;
    start_xfer(24'h000500, 1);
    abort_i = 0;
    wait_idle("start_abort");
    verify("start_abort", 24'h000500, 1);
    mem[24'h600] = 8'h11; mem[24'h601] = 8'h22; mem[24'h602] = 8'h33; mem[24'h603] = 8'h44;
    start_xfer(24'h000600, 1);
    wait_idle("order");
    verify("order", 24'h000600, 1);
`ifdef FETCH_BSWAP_EN
    check("order_const", w_q.size() > 0 ? w_q[0] : 32'hx, 32'h11223344);
`else
    check("order_const", w_q.size() > 0 ? w_q[0] : 32'hx, 32'h44332211);
`endif
    start_xfer(24'h000700, 3);
    repeat (6) @(negedge clk_i);
    #2 rst_i = 1;
    #1;
    check("rst_mid_flags", {busy_o, done_o, flash_valid_o, word_valid_o, word_last_o}, 0);
    check("rst_mid_addr", flash_addr_o, 0);
    check("rst_mid_data", word_data_o, 0);
    @(negedge clk_i);
    rst_i = 0;
    repeat (3) @(negedge clk_i);
    check("rst_mid_done", done_cnt, 0);
    check("rst_mid_idle", busy_o, 0);
    for (int k = 0; k < 8; k++) begin
      a = 24'($urandom);
      n = $urandom_range(1, 4);
      rdy_pct = $urandom_range(30, 100);
      start_xfer(a, n);
      if (k % 2 == 1) begin
        repeat (3) @(negedge clk_i);
        start_addr_i = a ^ 24'h5A5A5A; word_cnt_i = 16'd7; start_i = 1;
        @(negedge clk_i);
        start_i = 0;
      end
      wait_idle("rand");
      verify("rand", a, n);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/flash_word_fetcher.md
FLASH_WORD_FETCHER -- requirements
Module: flash_word_fetcher

Interface
REQ-001 SHALL have parameter LEN_W, default 16, giving the width of the word-count input.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, the asynchronous active-high reset.
REQ-004 SHALL have port start_i, input, 1, the fetch request, sampled in IDLE only.
REQ-005 SHALL have port start_addr_i, input, 24, the first flash byte address.
REQ-006 SHALL have port word_cnt_i, input, LEN_W, the number of 32-bit words to fetch.
REQ-007 SHALL have port abort_i, input, 1, which cancels the fetch in progress.
REQ-008 SHALL have port busy_o, output, 1, high whenever the state is not IDLE.
REQ-009 SHALL have port done_o, output, 1, a one-cycle pulse on normal completion.
REQ-010 SHALL have port flash_valid_o, output, 1, the byte-read request to spi_wrapper valid_i.
REQ-011 SHALL have port flash_ready_i, input, 1, from spi_wrapper ready_o.
REQ-012 SHALL have port flash_addr_o, output, 24, the byte address to spi_wrapper addr_i.
REQ-013 SHALL have port flash_rdata_i, input, 8, from spi_wrapper rdata_o, valid while flash_ready_i is high.
REQ-014 SHALL have port word_valid_o, output, 1, the assembled-word valid.
REQ-015 SHALL have port word_ready_i, input, 1, the consumer ready.
REQ-016 SHALL have port word_data_o, output, 32, the assembled word.
REQ-017 SHALL have port word_last_o, output, 1, high together with word_valid_o on the final word.

Function
REQ-018 SHALL implement states IDLE, REQ, GAP, OUT, DONE.
REQ-019 In IDLE, start_i=1 with word_cnt_i!=0 SHALL latch the address and count and enter REQ on the next cycle.
REQ-020 In IDLE, start_i=1 with word_cnt_i=0 SHALL enter DONE, pulse done_o for one cycle and perform no flash access.
REQ-021 In REQ, flash_valid_o SHALL be 1 and flash_addr_o SHALL remain stable until flash_valid_o & flash_ready_i.
REQ-022 On a byte handshake, flash_rdata_i SHALL be stored into byte lane k, where k is the 2-bit byte index with first byte = k0 = bits[7:0] (little-endian).
REQ-023 On a byte handshake, the address SHALL increment by 1 and wrap from 24'hFFFFFF to 24'h000000.
REQ-024 After a byte handshake, flash_valid_o SHALL be 0 for exactly one cycle (GAP) before the next request.
REQ-025 After the 4th byte of a word, the FSM SHALL enter OUT instead of GAP.
REQ-026 In OUT, word_valid_o SHALL be 1 and word_data_o and word_last_o SHALL be held stable until word_ready_i.
REQ-027 No flash request SHALL be issued while in OUT.
REQ-028 A word handshake that is not the last SHALL decrement the remaining count and enter REQ.
REQ-029 A word handshake on the last word SHALL enter DONE; done_o SHALL pulse in that cycle and the FSM SHALL return to IDLE the next cycle.
REQ-030 start_i SHALL be ignored while busy_o=1.
REQ-031 abort_i in REQ SHALL take effect only after the in-flight byte handshake completes, so that the SPI transaction is never truncated.
REQ-032 abort_i in GAP or OUT SHALL act immediately.
REQ-033 An abort SHALL return the FSM to IDLE, discard the partial word, leave done_o low and drop word_valid_o.
REQ-034 start_i and abort_i asserted in the same cycle in IDLE SHALL be treated as start.

Reset
REQ-035 While rst_i=1, asynchronously, the state SHALL be IDLE and busy_o, done_o, flash_valid_o, word_valid_o and word_last_o SHALL be 0.
REQ-036 While rst_i=1, flash_addr_o and word_data_o SHALL be 0 and the internal count and byte index SHALL be 0.
REQ-037 Reset asserted mid-operation SHALL abandon the transfer with no done_o pulse.
REQ-038 After reset release, the first start_i SHALL be accepted in the first cycle.

Configuration
REQ-039 When macro FETCH_BSWAP_EN is defined, bytes SHALL be packed big-endian, with the first byte in word_data_o[31:24].
REQ-040 When FETCH_BSWAP_EN is undefined, packing SHALL be little-endian per REQ-022.
REQ-041 All other behaviour SHALL be identical with and without FETCH_BSWAP_EN.

Verification
REQ-042 SHALL cover: start_addr=0, cnt=1, flash returns AA,BB,CC,DD -> word_data_o=32'hDDCCBBAA, word_last_o=1, done_o pulses once, 4 flash handshakes at addrs 0..3.
REQ-043 SHALL cover: cnt=2 with word_ready_i held 0 for 20 cycles -> word held stable, no flash_valid_o during the stall, 8 byte reads in total.
REQ-044 SHALL cover: start_addr=24'hFFFFFE, cnt=1 -> addresses FFFFFE, FFFFFF, 000000, 000001.
REQ-045 SHALL cover: cnt=0 -> done_o pulse one cycle after start, flash_valid_o never high.
REQ-046 SHALL cover: abort_i during the 2nd byte request -> that byte handshake completes, then IDLE, word_valid_o never high, no done_o pulse.
REQ-047 SHALL cover: FETCH_BSWAP_EN defined, bytes 11,22,33,44 -> word_data_o=32'h11223344.
